sram_bus_arbiter: RTL and testbench

- Shares the single SRAM-like bus (req/addr_ok/data_ok) between the instruction-fetch port and the MEM-stage data port.
- Data requests (MEM-stage load/store with byte strobes) have priority over instruction fetch.
- Once a request is presented on the bus, it is locked until accepted.
- Tracks outstanding transactions in an owner FIFO so read data is returned to the correct requester in order.

---
 rtl/sram_bus_arbiter_pkg.sv | 25 ++
 rtl/sram_owner_fifo.sv | 63 ++++++
 rtl/sram_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// rtl/sram_bus_arbiter_pkg.sv - shared widths, owner encodings and arbiter state type
package sram_bus_arbiter_pkg;

    localparam int SRAM_BUS_ADDR_W = 32;
    localparam int SRAM_BUS_DATA_W = 32;
    localparam int SRAM_STRB_W     = 4;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_D = 2'd1,
        ARB_HOLD_I = 2'd2
    } arb_state_e;

    function automatic int owner_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int owner_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_owner_fifo.sv
// rtl/sram_owner_fifo.sv - 1-bit owner FIFO ordering outstanding bus transactions
module sram_owner_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              push_owner,
    input  logic                              pop,
    output logic                              head_owner,
    output logic [owner_cnt_width(DEPTH)-1:0] count,
    output logic                              full,
    output logic                              empty
);

    localparam int PTR_W = owner_ptr_width(DEPTH);
    localparam int CNT_W = owner_cnt_width(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign head_owner = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - data-priority arbiter sharing one SRAM-like bus between fetch and MEM ports
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = SRAM_BUS_ADDR_W,
    parameter int DATA_W    = SRAM_BUS_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_req,
    input  logic [ADDR_W-1:0]      inst_addr,
    output logic                   inst_addr_ok,
    output logic                   inst_data_ok,
    output logic [DATA_W-1:0]      inst_rdata,
    input  logic                   data_req,
    input  logic                   data_we,
    input  logic [SRAM_STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]      data_addr,
    input  logic [DATA_W-1:0]      data_wdata,
    output logic                   data_addr_ok,
    output logic                   data_data_ok,
    output logic [DATA_W-1:0]      data_rdata,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [SRAM_STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic                   bus_addr_ok,
    input  logic                   bus_data_ok,
    input  logic [DATA_W-1:0]      bus_rdata,
    output logic                   resp_err
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       grant;
    logic       owner;
    logic       accept;
    logic       full;
    logic       empty;
    logic       head_owner;
    logic       resp_pop;
    logic [owner_cnt_width(MAX_OUTST)-1:0] fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A full FIFO blocks new selection in IDLE; a HOLD state can never be full
    // because nothing was pushed since the request was first presented.
    always_comb begin
        grant   = 1'b0;
        owner   = OWNER_INST;
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (!full && data_req) begin
                    grant = 1'b1;
                    owner = OWNER_DATA;
                end else if (!full && inst_req) begin
                    grant = 1'b1;
                    owner = OWNER_INST;
                end
                if (grant && !bus_addr_ok) begin
                    state_d = (owner == OWNER_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
                end
            end
            ARB_HOLD_D: begin
                grant = 1'b1;
                owner = OWNER_DATA;
                if (bus_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_HOLD_I: begin
                grant = 1'b1;
                owner = OWNER_INST;
                if (bus_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign accept       = grant & bus_addr_ok;
    assign inst_addr_ok = accept & (owner == OWNER_INST);
    assign data_addr_ok = accept & (owner == OWNER_DATA);

    assign bus_req   = grant;
    assign bus_we    = grant & (owner == OWNER_DATA) & data_we;
    assign bus_wstrb = (grant && owner == OWNER_DATA) ? data_wstrb : '0;
    assign bus_addr  = (owner == OWNER_DATA) ? data_addr : inst_addr;
    assign bus_wdata = data_wdata;

    assign resp_pop     = bus_data_ok & ~empty;
    assign inst_data_ok = resp_pop & (head_owner == OWNER_INST);
    assign data_data_ok = resp_pop & (head_owner == OWNER_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else if (bus_data_ok && empty) begin
            resp_err <= 1'b1;
        end
    end

    sram_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_owner (owner),
        .pop        (resp_pop),
        .head_owner (head_owner),
        .count      (fifo_count),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed and randomized checks of sram_bus_arbiter against a queue model
module tb_sram_bus_arbiter;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: current lock holder (-1 none, 0 inst, 1 data), in-order owner queue, sticky error.
    int locked;
    bit q[$];
    bit m_err;
    int m_g;
    bit m_acc, m_pop, m_empty_resp;
    logic [3:0] strb_tab [7];

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTST(MAX), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        locked = -1;
        m_err  = 1'b0;
    endtask

    // Settle after the input change, then compare every output against the model.
    task automatic settle_check();
        bit full_now;
        #1;
        full_now = (q.size() == MAX);
        if (locked != -1)               m_g = locked;
        else if (!full_now && data_req) m_g = 1;
        else if (!full_now && inst_req) m_g = 0;
        else                            m_g = -1;
        m_acc        = (m_g != -1) && bus_addr_ok;
        m_pop        = bus_data_ok && (q.size() > 0);
        m_empty_resp = bus_data_ok && (q.size() == 0);
        chk("bus_req", bus_req, m_g != -1);
        chk("bus_we", bus_we, (m_g == 1) && data_we);
        chk("bus_wstrb", bus_wstrb, (m_g == 1) ? data_wstrb : 4'h0);
        if (m_g == 1) chk("bus_addr_d", bus_addr, data_addr);
        if (m_g == 0) chk("bus_addr_i", bus_addr, inst_addr);
        if (m_g == 1) chk("bus_wdata", bus_wdata, data_wdata);
        chk("inst_addr_ok", inst_addr_ok, m_acc && m_g == 0);
        chk("data_addr_ok", data_addr_ok, m_acc && m_g == 1);
        chk("inst_data_ok", inst_data_ok, m_pop && q[0] == 1'b0);
        chk("data_data_ok", data_data_ok, m_pop && q[0] == 1'b1);
        if (m_pop && q[0] == 1'b0) chk("inst_rdata", inst_rdata, bus_rdata);
        if (m_pop && q[0] == 1'b1) chk("data_rdata", data_rdata, bus_rdata);
        chk("resp_err", resp_err, m_err);
        chk("count", dut.fifo_count, q.size());
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(m_g == 1);
        locked = (m_g != -1 && !m_acc) ? m_g : -1;
        if (m_empty_resp) m_err = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        strb_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        rst_n = 1'b0;
        inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        model_reset();
        @(negedge clk);
        settle_check();
        @(negedge clk);
        rst_n = 1'b1;

        // single fetch, response two cycles later
        inst_req = 1; inst_addr = 32'h1C000000; bus_addr_ok = 1;
        settle_check();
        chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 0; bus_addr_ok = 0;
        settle_check();
        chk("t1_count1", dut.fifo_count, 1);
        tick();
        bus_data_ok = 1; bus_rdata = 32'h02C00421;
        settle_check();
        chk("t1_inst_data_ok", inst_data_ok, 1'b1);
        chk("t1_inst_rdata", inst_rdata, 32'h02C00421);
        tick();
        bus_data_ok = 0;
        settle_check();
        chk("t1_count0", dut.fifo_count, 0);
        tick();

        // data priority, then full blocks a fetch even across a pop
        inst_req = 1; inst_addr = 32'h1C000010; data_req = 1; data_we = 0;
        data_wstrb = 4'hF; data_addr = 32'h00001000; bus_addr_ok = 1;
        settle_check();
        chk("t2_bus_addr", bus_addr, 32'h00001000);
        chk("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 0;
        settle_check();
        chk("t2_inst_granted", inst_addr_ok, 1'b1);
        tick();
        inst_addr = 32'h1C000014;
        settle_check();
        chk("t5_full_blocks", bus_req, 1'b0);
        tick();
        bus_data_ok = 1; bus_rdata = 32'hAAAA0001;
        settle_check();
        chk("t5_pop_still_blocked", bus_req, 1'b0);
        chk("t5_first_resp_data", data_data_ok, 1'b1);
        tick();
        bus_data_ok = 0;
        settle_check();
        chk("t5_req_after_pop", bus_req, 1'b1);
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            bus_rdata = 32'hBBBB0000 + i;
            settle_check();
            chk("t5_inst_in_order", inst_data_ok, 1'b1);
            tick();
        end
        bus_data_ok = 0;

        // HOLD_I is not preempted by a later data request
        inst_req = 1; inst_addr = 32'h1C000020;
        settle_check(); tick();
        data_req = 1; data_addr = 32'h00002000;
        settle_check();
        chk("t3_hold_inst", bus_addr, 32'h1C000020);
        tick();
        bus_addr_ok = 1;
        settle_check();
        chk("t3_inst_accept", inst_addr_ok, 1'b1);
        chk("t3_data_wait", data_addr_ok, 1'b0);
        tick();
        inst_req = 0;
        settle_check();
        chk("t3_data_accept", data_addr_ok, 1'b1);
        tick();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        settle_check(); tick();
        settle_check(); tick();
        bus_data_ok = 0;

        // byte store
        data_req = 1; data_we = 1; data_wstrb = 4'b0100; data_addr = 32'h8002;
        data_wdata = 32'h5A5A5A5A; bus_addr_ok = 1;
        settle_check();
        chk("t4_bus_wstrb", bus_wstrb, 4'b0100);
        chk("t4_bus_wdata", bus_wdata, 32'h5A5A5A5A);
        chk("t4_bus_we", bus_we, 1'b1);
        tick();
        data_req = 0; data_we = 0; bus_addr_ok = 0;
        settle_check(); tick();
        bus_data_ok = 1;
        settle_check();
        chk("t4_store_done", data_data_ok, 1'b1);
        tick();

        // stray response with nothing outstanding
        settle_check();
        chk("t6_no_inst_ok", inst_data_ok, 1'b0);
        chk("t6_no_data_ok", data_data_ok, 1'b0);
        tick();
        bus_data_ok = 0;
        settle_check();
        chk("t6_err_set", resp_err, 1'b1);
        tick();
        settle_check();
        chk("t6_err_held", resp_err, 1'b1);
        tick();

        // asynchronous reset out of HOLD_I returns to IDLE, where data wins
        inst_req = 1; inst_addr = 32'h1C000030;
        settle_check(); tick();
        data_req = 1; data_addr = 32'h00003000;
        settle_check();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_err_clear", resp_err, 1'b0);
        chk("t6_rst_idle_data", bus_addr, 32'h00003000);
        chk("t6_rst_count", dut.fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        inst_req = 0; data_req = 0;
        settle_check(); tick();

        // randomized traffic with hold-until-accept requesters
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit ia, da;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_we = $urandom_range(0, 1);
                data_wstrb = strb_tab[$urandom_range(0, 6)];
                data_addr = $urandom; data_wdata = $urandom;
            end
            bus_addr_ok = $urandom_range(0, 1);
            bus_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus_rdata   = $urandom;
            settle_check();
            ia = m_acc && m_g == 0;
            da = m_acc && m_g == 1;
            tick();
            if (ia) inst_req = 0;
            if (da) data_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
